// File: rtl/alib_cbuf_pkg.sv
// Shared definitions for the circular-buffer read arbiter.
//   rd_state_e : burst FSM state encoding (IDLE / BURST)
//   idx_w()    : width of a requester id, never less than one bit
package alib_cbuf_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alib_cbuf_read_arbiter_if.sv
// Requester-side bundle of the circular-buffer read arbiter.
//   req / req_index / req_len : per-requester request level, start index
//                               (0 = newest entry) and burst length minus one
//   grant                     : one-hot acceptance pulse
//   rsp_*                     : response beat (valid, data, owner id, last, error)
// master = requester side, slave = arbiter side.
interface alib_cbuf_read_arbiter_if
  import alib_cbuf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_index;
  logic [NUM_REQ*AW-1:0] req_len;
  logic [NUM_REQ-1:0]    grant;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [IW-1:0]         rsp_id;
  logic                  rsp_last;
  logic                  rsp_err;

  modport master (
    output req, req_index, req_len,
    input  grant, rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
  );

  modport slave (
    input  req, req_index, req_len,
    output grant, rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
  );

endinterface

// File: rtl/alib_rr_arbiter.sv
// Round-robin selector.
//   clk, rst  : clock, synchronous active-high reset
//   en        : allows a grant this cycle
//   req       : request vector
//   grant     : one-hot grant (combinational)
//   grant_id  : binary index of the granted requester
// The search starts one past the last granted requester. After reset the
// pointer sits on the highest index so requester 0 wins first.
module alib_rr_arbiter
  import alib_cbuf_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          grant,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id
);
  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0] ptr_q;
  logic          found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (en && !found && req[(int'(ptr_q) + off) % NUM_REQ]) begin
        grant[(int'(ptr_q) + off) % NUM_REQ] = 1'b1;
        grant_id = IW'((int'(ptr_q) + off) % NUM_REQ);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(NUM_REQ - 1);
    end else if (found) begin
      ptr_q <= grant_id;
    end
  end

endmodule

// File: rtl/alib_cbuf_read_arbiter.sv
// Shares one circular-buffer read port between NUM_REQ requesters.
//   clk, rst       : clock, synchronous active-high reset
//   rd_if (slave)  : requests, grants and response beats
//   cb_read_index  : buffer read index (relative, 0 = newest); 0 when idle
//   cb_data_out    : registered buffer data, valid one cycle after the index
//   cb_empty       : buffer empty flag, sampled in the grant cycle
//   busy           : high while a burst is being issued
// A grant latches the request; each following cycle issues one read. The
// response leaves one cycle after its read, carrying the buffer data
// straight through. A grant against an empty buffer issues no reads and
// instead returns a single error beat two cycles later.
module alib_cbuf_read_arbiter
  import alib_cbuf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  alib_cbuf_read_arbiter_if.slave    rd_if,
  output logic [$clog2(DEPTH)-1:0]   cb_read_index,
  input  logic [WIDTH-1:0]           cb_data_out,
  input  logic                       cb_empty,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = idx_w(NUM_REQ);

  rd_state_e          state_q;
  rd_state_e          state_d;
  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_id;
  logic               gnt_any;

  logic [AW-1:0]      lat_index;
  logic [AW-1:0]      lat_len;
  logic [AW-1:0]      beat_cnt;
  logic [IW-1:0]      lat_id;
  logic               issue;
  logic               beat_last;

  logic               err_vld_p0;
  logic [IW-1:0]      err_id_p0;

  logic               rsp_vld_p1;
  logic               rsp_last_p1;
  logic               rsp_err_p1;
  logic [IW-1:0]      rsp_id_p1;

  // Gating with rst keeps grant low while reset is held.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  alib_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .en       (arb_en),
    .req      (rd_if.req),
    .grant    (gnt),
    .grant_id (gnt_id)
  );

  assign gnt_any     = |gnt;
  assign rd_if.grant = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_any && !cb_empty) state_d = ST_BURST;
      ST_BURST: if (beat_last)            state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == ST_BURST);
    issue         = busy;
    beat_last     = busy && (beat_cnt == lat_len);
    // AW-bit addition wraps DEPTH-1 -> 0 on its own.
    cb_read_index = busy ? (lat_index + beat_cnt) : '0;
  end

  always_ff @(posedge clk) begin
    if (gnt_any) begin
      lat_index <= rd_if.req_index[gnt_id*AW +: AW];
      lat_len   <= rd_if.req_len[gnt_id*AW +: AW];
      lat_id    <= gnt_id;
      beat_cnt  <= '0;
    end else if (issue) begin
      beat_cnt  <= beat_cnt + 1'b1;
    end
  end

  // ---- p0: empty-buffer error held back one cycle to match read latency ----
  always_ff @(posedge clk) begin
    if (rst) begin
      err_vld_p0 <= 1'b0;
    end else begin
      err_vld_p0 <= gnt_any && cb_empty;
    end
    err_id_p0 <= gnt_id;
  end

  // ---- p1: response beat, aligned with registered buffer data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_p1  <= 1'b0;
      rsp_last_p1 <= 1'b0;
      rsp_err_p1  <= 1'b0;
    end else begin
      rsp_vld_p1  <= issue || err_vld_p0;
      rsp_last_p1 <= beat_last || err_vld_p0;
      rsp_err_p1  <= err_vld_p0;
    end
    rsp_id_p1 <= err_vld_p0 ? err_id_p0 : lat_id;
  end

  assign rd_if.rsp_valid = rsp_vld_p1;
  assign rd_if.rsp_data  = (rsp_vld_p1 && !rsp_err_p1) ? cb_data_out : '0;
  assign rd_if.rsp_id    = rsp_vld_p1 ? rsp_id_p1 : '0;
  assign rd_if.rsp_last  = rsp_last_p1;
  assign rd_if.rsp_err   = rsp_err_p1;

endmodule

// File: tb/tb_alib_cbuf_read_arbiter.sv
// Bench for alib_cbuf_read_arbiter. The attached buffer holds 10..25 with
// 25 newest, so relative index i reads back 25 - i one cycle later.
// Each observed grant pushes the expected read indices and response beats
// (with their due cycle) into queues that are drained as the DUT responds.
module tb_alib_cbuf_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 16;
  localparam int WIDTH   = 8;
  localparam int AW      = 4;

  typedef struct {
    int data;
    int id;
    int last;
    int err;
    int cyc;
  } exp_rsp_t;

  logic             clk;
  logic             rst;
  logic [AW-1:0]    cb_read_index;
  logic [WIDTH-1:0] cb_data_out;
  logic             cb_empty;
  logic             busy;

  alib_cbuf_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) rd_if ();

  alib_cbuf_read_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_if         (rd_if),
    .cb_read_index (cb_read_index),
    .cb_data_out   (cb_data_out),
    .cb_empty      (cb_empty),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int gnt_count = 0;
  int next_gnt_cyc = 0;
  bit hold_req  = 1'b0;
  bit b2b_armed = 1'b0;
  int r_idx [NUM_REQ];
  int r_len [NUM_REQ];
  logic [NUM_REQ-1:0] pending_set;
  logic [NUM_REQ-1:0] pending_clear;

  int       exp_gnt_q [$];
  int       exp_idx_q [$];
  exp_rsp_t exp_rsp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cb_data_out <= 8'(25 - int'(cb_read_index));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  task automatic set_req(input int i, input int idx, input int len);
    r_idx[i] = idx;
    r_len[i] = len;
    rd_if.req_index[i*AW +: AW] = AW'(idx);
    rd_if.req_len[i*AW +: AW]   = AW'(len);
    pending_set[i] = 1'b1;
  endtask

  task automatic monitor();
    exp_rsp_t e;
    int gid;
    if (rd_if.grant != '0) begin
      gid = 0;
      for (int i = 0; i < NUM_REQ; i++) if (rd_if.grant[i]) gid = i;
      chk_val("grant_onehot", $countones(rd_if.grant), 1);
      chk_val("grant_while_busy", int'(busy), 0);
      if (exp_gnt_q.size() > 0) chk_val("grant_order", gid, exp_gnt_q.pop_front());
      else chk_val("grant_unexpected", gid, -1);
      if (b2b_armed) chk_val("grant_cycle", cycle, next_gnt_cyc);
      gnt_count++;
      if (cb_empty) begin
        e.data = 0; e.id = gid; e.last = 1; e.err = 1; e.cyc = cycle + 2;
        exp_rsp_q.push_back(e);
        next_gnt_cyc = cycle + 1;
      end else begin
        for (int k = 0; k <= r_len[gid]; k++) begin
          exp_idx_q.push_back((r_idx[gid] + k) % DEPTH);
          e.data = 25 - ((r_idx[gid] + k) % DEPTH);
          e.id   = gid;
          e.last = (k == r_len[gid]) ? 1 : 0;
          e.err  = 0;
          e.cyc  = cycle + 2 + k;
          exp_rsp_q.push_back(e);
        end
        next_gnt_cyc = cycle + r_len[gid] + 2;
      end
      if (hold_req) begin
        b2b_armed = 1'b1;
        if (exp_gnt_q.size() == 0) pending_clear = '1;
      end else begin
        pending_clear[gid] = 1'b1;
      end
    end

    if (busy) begin
      if (exp_idx_q.size() > 0) chk_val("rd_index", int'(cb_read_index), exp_idx_q.pop_front());
      else chk_val("rd_unexpected_busy", int'(busy), 0);
    end else begin
      chk_val("rd_index_idle", int'(cb_read_index), 0);
    end

    if (rd_if.rsp_valid) begin
      if (exp_rsp_q.size() > 0) begin
        e = exp_rsp_q.pop_front();
        chk_val("rsp_data",  int'(rd_if.rsp_data), e.data);
        chk_val("rsp_id",    int'(rd_if.rsp_id),   e.id);
        chk_val("rsp_last",  int'(rd_if.rsp_last), e.last);
        chk_val("rsp_err",   int'(rd_if.rsp_err),  e.err);
        chk_val("rsp_cycle", cycle,                e.cyc);
      end else begin
        chk_val("rsp_unexpected", int'(rd_if.rsp_valid), 0);
      end
    end
  endtask

  // Requests change just after the rising edge so the grant they cause is
  // visible to the monitor at the following falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    rd_if.req = (rd_if.req & ~pending_clear) | pending_set;
    pending_clear = '0;
    pending_set   = '0;
    @(negedge clk);
    cycle++;
    monitor();
  endtask

  task automatic run_until_idle(input int budget);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (rd_if.req == '0) && (pending_set == '0) && !busy && !rd_if.rsp_valid &&
             (exp_gnt_q.size() == 0) && (exp_idx_q.size() == 0) && (exp_rsp_q.size() == 0);
    end
    chk_val("idle_reached", int'(done), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk_val({tag, "_grant"},     int'(rd_if.grant),     0);
    chk_val({tag, "_rsp_valid"}, int'(rd_if.rsp_valid), 0);
    chk_val({tag, "_rsp_data"},  int'(rd_if.rsp_data),  0);
    chk_val({tag, "_rsp_id"},    int'(rd_if.rsp_id),    0);
    chk_val({tag, "_rsp_last"},  int'(rd_if.rsp_last),  0);
    chk_val({tag, "_rsp_err"},   int'(rd_if.rsp_err),   0);
    chk_val({tag, "_busy"},      int'(busy),            0);
    chk_val({tag, "_rd_index"},  int'(cb_read_index),   0);
  endtask

  initial begin
    int start_cnt;
    rst             = 1'b1;
    cb_empty        = 1'b0;
    rd_if.req       = '0;
    rd_if.req_index = '0;
    rd_if.req_len   = '0;
    pending_set     = '0;
    pending_clear   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_idx[i] = 0;
      r_len[i] = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Contention: all four held; requester 0 wins first after reset.
    hold_req = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, i * 3, i);
    exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(3);
    exp_gnt_q.push_back(0);
    run_until_idle(80);
    hold_req  = 1'b0;
    b2b_armed = 1'b0;

    // Single request: index 2, four beats -> 23,22,21,20.
    set_req(1, 2, 3);
    exp_gnt_q.push_back(1);
    run_until_idle(20);

    // Wrap: 14,15,0,1.
    set_req(0, 14, 3);
    exp_gnt_q.push_back(0);
    run_until_idle(20);

    // Full-depth burst.
    set_req(3, 5, DEPTH - 1);
    exp_gnt_q.push_back(3);
    run_until_idle(40);

    // Empty buffer: single error beat, no reads.
    cb_empty = 1'b1;
    set_req(2, 7, 5);
    exp_gnt_q.push_back(2);
    run_until_idle(20);
    cb_empty = 1'b0;

    // Reset during beat 2 of an eight-beat burst.
    set_req(2, 0, 7);
    exp_gnt_q.push_back(2);
    start_cnt = gnt_count;
    for (int n = 0; n < 10 && gnt_count == start_cnt; n++) step();
    chk_val("mid_reset_grant_seen", gnt_count - start_cnt, 1);
    step();
    step();
    step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    cycle++;
    check_zero_outputs("mid_reset");
    exp_idx_q.delete();
    exp_rsp_q.delete();
    rst = 1'b0;
    set_req(1, 4, 1);
    set_req(3, 9, 0);
    exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(3);
    run_until_idle(30);

    chk_val("grants_total", gnt_count, 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alib_cbuf_read_arbiter.md
ALIB_CBUF_READ_ARBITER -- requirements
Module: alib_cbuf_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of read requesters sharing one circular-buffer read port.
REQ-002 Parameter DEPTH, default 16: depth of the attached circular buffer; AW = $clog2(DEPTH).
REQ-003 Parameter WIDTH, default 8: data width of the attached circular buffer.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester request level; held until the matching grant bit pulses.
REQ-007 req_index  in  NUM_REQ*AW  per-requester start index, relative to newest entry (0 = newest); slice i belongs to requester i.
REQ-008 req_len  in  NUM_REQ*AW  per-requester burst length minus one (0 = 1 beat, DEPTH-1 = DEPTH beats).
REQ-009 grant  out  NUM_REQ  one-hot, one-cycle pulse accepting a request.
REQ-010 cb_read_index  out  AW  drives the buffer read_index (relative addressing mode).
REQ-011 cb_data_out  in  WIDTH  buffer data_out, registered in the buffer, valid one cycle after cb_read_index.
REQ-012 cb_empty  in  1  buffer empty flag.
REQ-013 rsp_valid / rsp_data[WIDTH] / rsp_id[$clog2(NUM_REQ)] / rsp_last / rsp_err  out: response beat, data, owning requester, final beat, empty-buffer error.
REQ-014 busy  out  1  high while state is BURST.

Function
REQ-015 FSM states IDLE and BURST SHALL be the only states.
REQ-016 In IDLE with any req bit set, the arbiter SHALL pulse grant for exactly one requester chosen round-robin, search starting at last-granted+1 modulo NUM_REQ.
REQ-017 On grant (cycle T) the arbiter SHALL latch index, len and id, clear its beat counter and enter BURST at T+1.
REQ-018 In BURST, beat k (k = 0..len, cycle T+1+k) SHALL drive cb_read_index = (index + k) mod DEPTH, wrapping from DEPTH-1 to 0.
REQ-019 rsp_valid SHALL assert at T+2+k for every beat, with rsp_data = cb_data_out, rsp_id = latched id, and rsp_last high only for k = len.
REQ-020 After issuing beat len, the FSM SHALL return to IDLE; a new grant MAY occur in the next cycle (T+2+len), overlapping the previous burst's final response beat.
REQ-021 No grant SHALL be issued while in BURST; pending req bits wait.
REQ-022 If cb_empty is high in the grant cycle, no reads SHALL be issued; a single beat SHALL be returned at T+2 with rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0, and the FSM SHALL remain in IDLE.
REQ-023 rsp_err SHALL be 0 on all non-error beats; cb_read_index SHALL hold 0 when not issuing.
REQ-024 Beat counter and index adder SHALL be AW bits wide; wrap SHALL occur by natural AW-bit truncation (DEPTH is a power of two).

Reset
REQ-025 On rst high at a clock edge: state=IDLE, grant=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_last=0, rsp_err=0, busy=0, cb_read_index=0, round-robin pointer set so requester 0 has highest priority.
REQ-026 Reset asserted mid-burst SHALL abort the burst; no rsp_valid SHALL appear in the cycle after reset.

Structure
REQ-027 State encodings (IDLE, BURST) SHALL reside in a shared package alib_cbuf_pkg.
REQ-028 The round-robin selector SHALL be a sub-module alib_rr_arbiter (NUM_REQ-wide, one-hot grant, enable input, pointer update on grant).

Verification
REQ-029 Single request: req[1]=1, index=2, len=3, buffer holding 10,11,...,25 (newest 25) -> grant[1] at T, cb_read_index 2,3,4,5, rsp_data 23,22,21,20, rsp_last on 4th beat, rsp_id=1.
REQ-030 Contention: req=4'b1111 held -> grant order 0,1,2,3,0, no overlap of bursts.
REQ-031 Wrap: index=14, len=3, DEPTH=16 -> cb_read_index 14,15,0,1.
REQ-032 Empty: cb_empty=1, req[2]=1 -> grant[2], one beat rsp_err=1, rsp_last=1, no cb_read_index change.
REQ-033 Reset mid-burst: rst at beat 2 of a len=7 burst -> next cycle all outputs 0, busy=0, next grant goes to lowest-index active requester.
